feedback_scorer: RTL and testbench
==================================

FEEDBACK_SCORER -- requirements
Module: feedback_scorer

Interface
REQ-001 Parameter: NUM_PEGS, default 4, number of pegs per code; legal range 1..5 so that counts fit 3 bits.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to score; honoured only in IDLE.
REQ-005 guess  input  3*NUM_PEGS  player guess; peg i in bits [3i+2:3i], 3-bit color code.
REQ-006 secret  input  3*NUM_PEGS  hidden code, same packing as guess.
REQ-007 c_place  output  3  count of pegs with right color in right position; drives the feedback peg drawer.
REQ-008 c_color  output  3  count of right colors in wrong positions, excluding pegs already counted in c_place.
REQ-009 win  output  1  high when c_place equals NUM_PEGS.
REQ-010 busy  output  1  high while scoring is in progress (EXACT, COLOR states).
REQ-011 done  output  1  one-cycle pulse when results update; intended to drive the drawer's restart input.

Function
REQ-012 States: IDLE, EXACT, COLOR, DONE; DONE returns to IDLE unconditionally after one cycle.
REQ-013 In IDLE, start=1 at an edge latches guess and secret into internal registers, clears internal counters and all used flags, and enters EXACT; guess and secret may change freely afterwards.
REQ-014 EXACT: index i steps 0..NUM_PEGS-1, one peg per cycle; if g[i]==s[i], increment the place counter and set guess_used[i] and secret_used[i].
REQ-015 COLOR: pair (i,j) is stepped with i outer and j inner, one pair per cycle, for exactly NUM_PEGS*NUM_PEGS cycles regardless of the data.
REQ-016 In COLOR, if !guess_used[i] && !secret_used[j] && g[i]==s[j], increment the color counter and set guess_used[i] and secret_used[j].
REQ-017 Latency is fixed: with start sampled at edge 0, EXACT occupies cycles 1..NUM_PEGS and COLOR occupies cycles NUM_PEGS+1..NUM_PEGS+NUM_PEGS^2.
REQ-018 DONE occupies cycle NUM_PEGS+NUM_PEGS^2+1, which is cycle 21 for NUM_PEGS=4.
REQ-019 c_place, c_color and win are loaded from the internal counters on the edge that enters DONE, and are held stable until the next such edge; intermediate counts are never visible.
REQ-020 done=1 only in the DONE cycle; busy=1 only in EXACT and COLOR; done and busy are never high together.
REQ-021 start is ignored in EXACT, COLOR and DONE, with no queueing; a start held high continuously restarts from IDLE, giving one result every NUM_PEGS+NUM_PEGS^2+2 cycles (22 for NUM_PEGS=4).
REQ-022 Counters are 3-bit unsigned and can never exceed NUM_PEGS, so no wrap occurs; c_place+c_color<=NUM_PEGS always holds.
REQ-023 Duplicate colors in guess or secret are each matched at most once, via the used flags.

Reset
REQ-024 resetn=0 at any edge, in any state, forces IDLE and sets c_place=0, c_color=0, win=0, busy=0, done=0; internal counters, indices and used flags are cleared.
REQ-025 resetn=0 takes priority over start at the same edge.
REQ-026 Reset during EXACT or COLOR aborts scoring: no done pulse is produced and outputs are not updated.
REQ-027 The first start after reset deasserts is accepted normally.

Verification (NUM_PEGS=4, pegs listed peg0..peg3)
REQ-028 Exact match: secret 1,2,3,4, guess 1,2,3,4, start -> done in cycle 21; c_place=4, c_color=0, win=1; busy high in cycles 1..20.
REQ-029 Permutation: secret 1,2,3,4, guess 4,3,2,1 -> c_place=0, c_color=4, win=0.
REQ-030 Duplicates: secret 1,1,2,2, guess 1,2,1,3 -> c_place=1, c_color=2.
REQ-031 No match: secret 0,1,2,3, guess 5,5,5,5 -> c_place=0, c_color=0, win=0; the done pulse is still produced in cycle 21.
REQ-032 Reset mid-score: assert resetn=0 in cycle 10 -> next cycle all outputs 0, busy=0, no done.
REQ-033 Rescore after reset mid-score: new start after reset -> correct result in cycle 21 relative to that start.
REQ-034 Start protocol: start pulsed in cycle 5 while busy -> ignored, exactly one done.
REQ-035 Start held high: start held high for 100 cycles -> done pulses exactly 22 cycles apart; outputs stable between pulses.

Source files
------------

// File: rtl/feedback_scorer.sv
// Mastermind-style scorer: counts exact-position and color-only matches between a latched
// guess and secret, one peg (EXACT) or one peg pair (COLOR) per cycle, with fixed latency.
module feedback_scorer #(
   parameter int NUM_PEGS = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    start,
   input  logic [3*NUM_PEGS-1:0]   guess,
   input  logic [3*NUM_PEGS-1:0]   secret,
   output logic [2:0]              c_place,
   output logic [2:0]              c_color,
   output logic                    win,
   output logic                    busy,
   output logic                    done
);

   localparam int IW = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_PEGS - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXACT, S_COLOR, S_DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [3*NUM_PEGS-1:0]   r_g;
   logic [3*NUM_PEGS-1:0]   r_s;
   logic [IW-1:0]           r_i;
   logic [IW-1:0]           r_j;
   logic [NUM_PEGS-1:0]     r_gused;
   logic [NUM_PEGS-1:0]     r_sused;
   logic [2:0]              r_place;
   logic [2:0]              r_color;

   logic [2:0]              w_g [NUM_PEGS];
   logic [2:0]              w_s [NUM_PEGS];
   logic                    w_exact_hit;
   logic                    w_color_hit;
   logic                    w_last_pair;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PEGS; gi++) begin : g_unpack
         assign w_g[gi] = r_g[3*gi +: 3];
         assign w_s[gi] = r_s[3*gi +: 3];
      end
   endgenerate

   assign w_exact_hit = (w_g[r_i] == w_s[r_i]);
   assign w_color_hit = !r_gused[r_i] && !r_sused[r_j] && (w_g[r_i] == w_s[r_j]);
   assign w_last_pair = (r_i == LAST) && (r_j == LAST);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_EXACT;
         end
         S_EXACT: begin
            busy = 1'b1;
            if (r_i == LAST) w_state_next = S_COLOR;
         end
         S_COLOR: begin
            busy = 1'b1;
            if (w_last_pair) w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_g     <= '0;
         r_s     <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_gused <= '0;
         r_sused <= '0;
         r_place <= '0;
         r_color <= '0;
         c_place <= '0;
         c_color <= '0;
         win     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_g     <= guess;
                  r_s     <= secret;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_gused <= '0;
                  r_sused <= '0;
                  r_place <= '0;
                  r_color <= '0;
               end
            end
            S_EXACT: begin
               if (w_exact_hit) begin
                  r_place        <= r_place + 3'd1;
                  r_gused[r_i]   <= 1'b1;
                  r_sused[r_i]   <= 1'b1;
               end
               r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
            end
            S_COLOR: begin
               if (w_color_hit) begin
                  r_color        <= r_color + 3'd1;
                  r_gused[r_i]   <= 1'b1;
                  r_sused[r_j]   <= 1'b1;
               end
               if (r_j == LAST) begin
                  r_j <= '0;
                  r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
               end else begin
                  r_j <= r_j + 1'b1;
               end
               // The final pair's hit is folded in here, since r_color only updates on this same edge.
               if (w_last_pair) begin
                  c_place <= r_place;
                  c_color <= r_color + {2'b00, w_color_hit};
                  win     <= (r_place == 3'(NUM_PEGS));
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_feedback_scorer.sv
// Directed-vector bench for feedback_scorer: the driver queues hand-computed results with their
// due cycle, and a negedge monitor checks every done pulse, reset behaviour and output stability.
module tb_feedback_scorer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [11:0] guess = '0;
   logic [11:0] secret = '0;
   logic [2:0]  c_place;
   logic [2:0]  c_color;
   logic        win;
   logic        busy;
   logic        done;

   typedef struct {
      int         cyc;
      logic [2:0] p;
      logic [2:0] c;
      logic       w;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   rst_at_edge = 1'b0;
   int   busy_cnt = 0;
   logic [2:0] last_p = '0;
   logic [2:0] last_c = '0;
   logic       last_w = 1'b0;

   feedback_scorer #(.NUM_PEGS(4)) dut (
      .clk(clk), .resetn(resetn), .start(start), .guess(guess), .secret(secret),
      .c_place(c_place), .c_color(c_color), .win(win), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      rst_at_edge = !resetn;
   end

   function automatic logic [11:0] pk(input int a0, input int a1, input int a2, input int a3);
      return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   always @(negedge clk) begin
      if (rst_at_edge) begin
         checks++;
         if (c_place != 0 || c_color != 0 || win != 0 || busy != 0 || done != 0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got place=%0d color=%0d win=%0d busy=%0d done=%0d want all 0",
                     cyc, c_place, c_color, win, busy, done);
         end
         last_p = '0; last_c = '0; last_w = 1'b0; busy_cnt = 0;
      end else begin
         if (done && busy) begin
            checks++; errors++;
            $display("FAIL done_busy_overlap cyc=%0d got done=1 busy=1 want not both", cyc);
         end
         if (done) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done cyc=%0d got done=1 want no pulse", cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               checks++;
               if (cyc != e.cyc) begin
                  errors++;
                  $display("FAIL done_latency got cyc=%0d want cyc=%0d", cyc, e.cyc);
               end
               checks++;
               if (c_place != e.p || c_color != e.c || win != e.w) begin
                  errors++;
                  $display("FAIL result cyc=%0d got place=%0d color=%0d win=%0d want place=%0d color=%0d win=%0d",
                           cyc, c_place, c_color, win, e.p, e.c, e.w);
               end
               checks++;
               if (busy_cnt != 20) begin
                  errors++;
                  $display("FAIL busy_cycles cyc=%0d got %0d want 20", cyc, busy_cnt);
               end
               $display("result cyc=%0d place=%0d color=%0d win=%0d", cyc, c_place, c_color, win);
               last_p = e.p; last_c = e.c; last_w = e.w;
            end
            busy_cnt = 0;
         end else begin
            if (busy) busy_cnt++;
            checks++;
            if (c_place != last_p || c_color != last_c || win != last_w) begin
               errors++;
               $display("FAIL output_stable cyc=%0d got place=%0d color=%0d win=%0d want place=%0d color=%0d win=%0d",
                        cyc, c_place, c_color, win, last_p, last_c, last_w);
            end
            if (q.size() != 0 && cyc > q[0].cyc) begin
               checks++; errors++;
               $display("FAIL done_timeout cyc=%0d got no done want done at cyc=%0d", cyc, q[0].cyc);
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic wait_idle();
      int b = 0;
      while (q.size() != 0 && b < 300) begin
         @(negedge clk);
         b++;
      end
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL wait_idle got %0d pending want 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   // mode 0: plain; mode 1: stray start pulse in cycle 5; mode 2: inputs scrambled after start.
   task automatic issue(input logic [11:0] g, input logic [11:0] s,
                        input int p, input int c, input int w, input int mode);
      exp_t e;
      wait_idle();
      guess = g; secret = s; start = 1'b1;
      e.cyc = cyc + 21; e.p = 3'(p); e.c = 3'(c); e.w = 1'(w);
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      if (mode == 2) begin
         guess = 12'($urandom);
         secret = 12'($urandom);
      end
      if (mode == 1) begin
         repeat (4) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      int c0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;

      issue(pk(1,2,3,4), pk(1,2,3,4), 4, 0, 1, 0);
      issue(pk(4,3,2,1), pk(1,2,3,4), 0, 4, 0, 0);
      issue(pk(1,2,1,3), pk(1,1,2,2), 1, 2, 0, 0);
      issue(pk(5,5,5,5), pk(0,1,2,3), 0, 0, 0, 0);
      issue(pk(7,2,0,2), pk(2,2,2,7), 1, 2, 0, 2);
      issue(pk(6,0,0,0), pk(6,6,6,6), 1, 0, 0, 1);
      issue(pk(1,2,3,4), pk(1,2,3,4), 4, 0, 1, 1);

      // Abort mid-score: reset sampled at the edge ending cycle 10, no result expected.
      wait_idle();
      guess = pk(4,3,2,1); secret = pk(1,2,3,4); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      checks++;
      if (busy != 1'b1) begin
         errors++;
         $display("FAIL busy_before_abort got busy=%0d want 1", busy);
      end
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      issue(pk(1,2,1,3), pk(1,1,2,2), 1, 2, 0, 0);

      // Start held high for 100 cycles: a fresh run every 22 cycles.
      wait_idle();
      guess = pk(7,2,0,2); secret = pk(2,2,2,7); start = 1'b1;
      c0 = cyc;
      for (int k = 0; k < 5; k++) begin
         exp_t e;
         e.cyc = c0 + 21 + 22 * k; e.p = 3'd1; e.c = 3'd2; e.w = 1'b0;
         q.push_back(e);
      end
      repeat (100) @(negedge clk);
      start = 1'b0;

      wait_idle();
      repeat (30) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
